enc_window_sampler: RTL and testbench

//  Multi-channel quadrature encoder front end for the motor loop. Per channel: synchronises A/B,

---
 rtl/enc_window_sampler.sv | 169 ++++++++++++++++
 tb/tb_enc_window_sampler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_window_sampler.sv
// Multi-channel x4 quadrature decoder that accumulates signed steps over a programmable window
// and latches them at window end. Define ENC_ERR_EN to add per-channel illegal-transition flags.
module enc_window_sampler #(
    parameter int NCH         = 2,
    parameter int CNT_W       = 8,
    parameter int WIN_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIN_W-1:0]     win_len_i,
    input  logic [NCH-1:0]       enc_a_i,
    input  logic [NCH-1:0]       enc_b_i,
    output logic [NCH*CNT_W-1:0] count_out_o,
    output logic [NCH-1:0]       dir_out_o,
    output logic [NCH-1:0]       ovf_o,
    output logic                 sample_stb_o
`ifdef ENC_ERR_EN
    ,
    output logic [NCH-1:0]       enc_err_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NCH-1:0] sync_a_q [SYNC_STAGES];
    logic [NCH-1:0] sync_b_q [SYNC_STAGES];
    logic [NCH-1:0] prev_a_q, prev_b_q;

    logic [WIN_W-1:0] wcnt_q, wcnt_d, wlen_q, wlen_d, eff_len;
    logic             terminal;

    logic [NCH-1:0][CNT_W-1:0] acc_q, acc_d, acc_sum;
    logic [NCH-1:0][CNT_W-1:0] count_q, count_d;
    logic [NCH-1:0] step_fwd, step_rev, step_ill;
    logic [NCH-1:0] ovf_win_q, ovf_win_d, ovf_sum, ovf_hit;
    logic [NCH-1:0] seen_q, seen_d, seen_sum;
    logic [NCH-1:0] dir_win_q, dir_win_d, dir_sum;
    logic [NCH-1:0] dir_out_q, dir_out_d, ovf_out_q, ovf_out_d;
    logic           stb_q, stb_d;
    logic [NCH-1:0][1:0] cur_idx, prv_idx, idx_diff;

    // Synchroniser and previous-state regs are never reset: they always track the pins,
    // so releasing reset cannot manufacture a step.
    always_ff @(posedge clk_i) begin
        sync_a_q[0] <= enc_a_i;
        sync_b_q[0] <= enc_b_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_a_q[s] <= sync_a_q[s-1];
            sync_b_q[s] <= sync_b_q[s-1];
        end
        prev_a_q <= sync_a_q[SYNC_STAGES-1];
        prev_b_q <= sync_b_q[SYNC_STAGES-1];
    end

    // Gray position index {A, A^B}: forward is +1 mod 4, a jump of 2 is illegal.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cur_idx[i]  = {sync_a_q[SYNC_STAGES-1][i],
                           sync_a_q[SYNC_STAGES-1][i] ^ sync_b_q[SYNC_STAGES-1][i]};
            prv_idx[i]  = {prev_a_q[i], prev_a_q[i] ^ prev_b_q[i]};
            idx_diff[i] = cur_idx[i] - prv_idx[i];
            step_fwd[i] = (idx_diff[i] == 2'd1);
            step_rev[i] = (idx_diff[i] == 2'd3);
            step_ill[i] = (idx_diff[i] == 2'd2);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            acc_sum[i] = acc_q[i];
            ovf_hit[i] = 1'b0;
            if (step_fwd[i]) begin
                if (acc_q[i] == CNT_MAX) ovf_hit[i] = 1'b1;
                else                     acc_sum[i] = acc_q[i] + CNT_ONE;
            end else if (step_rev[i]) begin
                if (acc_q[i] == CNT_MIN) ovf_hit[i] = 1'b1;
                else                     acc_sum[i] = acc_q[i] - CNT_ONE;
            end
            seen_sum[i] = seen_q[i] | step_fwd[i] | step_rev[i];
            dir_sum[i]  = step_fwd[i] ? 1'b1 : (step_rev[i] ? 1'b0 : dir_win_q[i]);
        end
        ovf_sum = ovf_win_q | ovf_hit;
    end

    // The window length is taken live from win_len_i on the wcnt==0 cycle, so a
    // one-cycle window (win_len=0) terminates every cycle.
    always_comb begin
        eff_len   = (wcnt_q == '0) ? win_len_i : wlen_q;
        terminal  = (wcnt_q == eff_len);
        wlen_d    = (wcnt_q == '0) ? win_len_i : wlen_q;
        wcnt_d    = wcnt_q + 1'b1;
        acc_d     = acc_sum;
        ovf_win_d = ovf_sum;
        seen_d    = seen_sum;
        dir_win_d = dir_sum;
        count_d   = count_q;
        dir_out_d = dir_out_q;
        ovf_out_d = ovf_out_q;
        stb_d     = terminal;
        if (terminal) begin
            wcnt_d    = '0;
            count_d   = acc_sum;
            ovf_out_d = ovf_sum;
            for (int i = 0; i < NCH; i++) begin
                dir_out_d[i] = seen_sum[i] ? dir_sum[i] : dir_out_q[i];
            end
            acc_d     = '0;
            ovf_win_d = '0;
            seen_d    = '0;
            dir_win_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wcnt_q    <= '0;
            wlen_q    <= '0;
            acc_q     <= '0;
            ovf_win_q <= '0;
            seen_q    <= '0;
            dir_win_q <= '0;
            count_q   <= '0;
            dir_out_q <= '0;
            ovf_out_q <= '0;
            stb_q     <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            wlen_q    <= wlen_d;
            acc_q     <= acc_d;
            ovf_win_q <= ovf_win_d;
            seen_q    <= seen_d;
            dir_win_q <= dir_win_d;
            count_q   <= count_d;
            dir_out_q <= dir_out_d;
            ovf_out_q <= ovf_out_d;
            stb_q     <= stb_d;
        end
    end

`ifdef ENC_ERR_EN
    logic [NCH-1:0] err_win_q, err_win_d, err_out_q, err_out_d;

    always_comb begin
        err_win_d = terminal ? '0 : (err_win_q | step_ill);
        err_out_d = terminal ? (err_win_q | step_ill) : err_out_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_win_q <= '0;
            err_out_q <= '0;
        end else begin
            err_win_q <= err_win_d;
            err_out_q <= err_out_d;
        end
    end

    assign enc_err_o = err_out_q;
`endif

    assign count_out_o  = count_q;
    assign dir_out_o    = dir_out_q;
    assign ovf_o        = ovf_out_q;
    assign sample_stb_o = stb_q;

endmodule

// File: tb/tb_enc_window_sampler.sv
// Scoreboard bench for enc_window_sampler: a window-level model predicts each strobe's cycle and
// latched values from the pin edges the driver applies. Works with or without ENC_ERR_EN.
module tb_enc_window_sampler;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int WIN_W = 8;
    localparam int MAXW  = 128;
    localparam int EW    = 32 + 3*NCH + NCH*CNT_W;
    localparam int CMAX  = (1 << (CNT_W-1)) - 1;
    localparam int CMIN  = -(1 << (CNT_W-1));

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [WIN_W-1:0]     win_len = 8'd255;
    logic [NCH-1:0]       enc_a = '0;
    logic [NCH-1:0]       enc_b = '0;
    logic [NCH*CNT_W-1:0] count_out;
    logic [NCH-1:0]       dir_out, ovf;
    logic                 sample_stb;
`ifdef ENC_ERR_EN
    logic [NCH-1:0]       enc_err;
`endif

    always #5 clk = ~clk;

    enc_window_sampler #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .win_len_i(win_len), .enc_a_i(enc_a), .enc_b_i(enc_b),
        .count_out_o(count_out), .dir_out_o(dir_out), .ovf_o(ovf), .sample_stb_o(sample_stb)
`ifdef ENC_ERR_EN
        , .enc_err_o(enc_err)
`endif
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Window model. cyc counts edges since reset release; an edge driven just after
    // edge cyc reaches the accumulator on edge cyc+3.
    logic [EW-1:0] exp_q[$];
    int  cyc = 0;
    int  fin_w = 0;
    int  l0 = 256;
    int  l1 = 256;
    bit  model_on = 0;
    int  sum_obs0 = 0;
    int  m_acc  [MAXW][NCH];
    bit  m_ovf  [MAXW][NCH];
    bit  m_seen [MAXW][NCH];
    bit  m_dir  [MAXW][NCH];
    bit  m_err  [MAXW][NCH];
    bit  carry_dir [NCH];

    function automatic int end_of(input int w);
        return (w == 0) ? l0 : l0 + w*l1;
    endfunction

    function automatic int win_of(input int u);
        return (u <= l0) ? 0 : 1 + (u - l0 - 1) / l1;
    endfunction

    task automatic push_win(input int w);
        logic [EW-1:0]        e;
        logic [NCH*CNT_W-1:0] c;
        logic [NCH-1:0]       d, o, r;
        logic [31:0]          t;
        for (int ch = 0; ch < NCH; ch++) begin
            t = m_acc[w][ch];
            c[ch*CNT_W +: CNT_W] = t[CNT_W-1:0];
            if (m_seen[w][ch]) carry_dir[ch] = m_dir[w][ch];
            d[ch] = carry_dir[ch];
            o[ch] = m_ovf[w][ch];
            r[ch] = m_err[w][ch];
        end
        t = end_of(w);
        e = {t, r, o, d, c};
        exp_q.push_back(e);
    endtask

    task automatic finalize();
        while (fin_w < MAXW && end_of(fin_w) <= cyc + 2) begin
            push_win(fin_w);
            fin_w++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (model_on) begin
            while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
                check("stb_missed", 64'd0, 64'd1);
                void'(exp_q.pop_front());
            end
            finalize();
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic drain();
        for (int g = 0; g < 64 && exp_q.size() > 0; g++) tick();
    endtask

    // kind: 1 forward, -1 reverse, 2 illegal (both pins flip), 0 nothing
    task automatic drive_step(input int ch, input int kind);
        logic [1:0] idx;
        int w;
        idx = {enc_a[ch], enc_a[ch] ^ enc_b[ch]};
        case (kind)
            1:       idx = idx + 2'd1;
            -1:      idx = idx - 2'd1;
            2:       idx = idx + 2'd2;
            default: idx = idx;
        endcase
        enc_a[ch] = idx[1];
        enc_b[ch] = idx[1] ^ idx[0];
        w = win_of(cyc + 3);
        if (w < MAXW) begin
            if (kind == 1 || kind == -1) begin
                m_seen[w][ch] = 1'b1;
                m_dir[w][ch]  = (kind == 1);
                if ((kind == 1 && m_acc[w][ch] == CMAX) || (kind == -1 && m_acc[w][ch] == CMIN))
                    m_ovf[w][ch] = 1'b1;
                else
                    m_acc[w][ch] += kind;
            end else if (kind == 2) begin
                m_err[w][ch] = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        while (exp_q.size() > 0 && int'(exp_q[exp_q.size()-1][EW-1 -: 32]) > cyc)
            void'(exp_q.pop_back());
        check("pending_at_rst", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b1;
        model_on = 0;
        @(posedge clk);
        #1;
        check("rst_count", count_out, 0);
        check("rst_dir", dir_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_stb", sample_stb, 0);
`ifdef ENC_ERR_EN
        check("rst_err", enc_err, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        fin_w = 0;
        l0 = int'(win_len) + 1;
        l1 = l0;
        sum_obs0 = 0;
        for (int w = 0; w < MAXW; w++)
            for (int ch = 0; ch < NCH; ch++) begin
                m_acc[w][ch] = 0; m_ovf[w][ch] = 0; m_seen[w][ch] = 0;
                m_dir[w][ch] = 0; m_err[w][ch] = 0;
            end
        for (int ch = 0; ch < NCH; ch++) carry_dir[ch] = 1'b0;
        model_on = 1;
        finalize();
    endtask

    logic [EW-1:0] mon_e;
    always @(negedge clk) begin
        if (model_on && !rst && sample_stb) begin
            if (exp_q.size() == 0) begin
                check("stb_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("stb_cycle", cyc, mon_e[EW-1 -: 32]);
                check("count", count_out, mon_e[NCH*CNT_W-1:0]);
                check("dir", dir_out, mon_e[NCH+NCH*CNT_W-1 -: NCH]);
                check("ovf", ovf, mon_e[2*NCH+NCH*CNT_W-1 -: NCH]);
`ifdef ENC_ERR_EN
                check("enc_err", enc_err, mon_e[3*NCH+NCH*CNT_W-1 -: NCH]);
`endif
                sum_obs0 += $signed(count_out[CNT_W-1:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle windows of 256, then +10/-6, saturation, recovery, illegal step, reset mid-window
        win_len = 8'd255;
        do_reset();
        tick_to(520);
        for (int j = 0; j < 10; j++) begin
            drive_step(0, 1);
            if (j < 6) drive_step(1, -1);
            repeat (4) tick();
        end
        tick_to(770);
        for (int j = 0; j < 200; j++) begin
            drive_step(0, 1);
            tick();
        end
        tick_to(1290);
        drive_step(1, 2);
        repeat (3) tick();
        drive_step(0, 1);
        tick();
        drive_step(0, 1);
        tick();
        tick_to(1600);
        for (int j = 0; j < 5; j++) begin
            drive_step(0, 1);
            drive_step(1, 1);
            repeat (2) tick();
        end
        tick_to(1636);
        do_reset();

        // win_len changed mid-window only applies from the next window
        tick_to(50);
        win_len = 8'd3;
        l1 = 4;
        tick_to(258);
        drive_step(1, 1);
        repeat (5) tick();
        drive_step(1, 1);
        tick_to(290);
        drain();

        // Step every cycle across 8-cycle window boundaries
        win_len = 8'd7;
        do_reset();
        tick_to(2);
        for (int j = 0; j < 45; j++) begin
            drive_step(0, 1);
            tick();
        end
        tick_to(80);
        drain();
        check("sum_ch0", sum_obs0, 45);

        // One-cycle windows: strobe stays high, count shows each cycle's step
        win_len = 8'd0;
        do_reset();
        tick_to(1);
        drive_step(0, 1);  tick();
        tick();
        drive_step(0, -1); drive_step(1, 1); tick();
        drive_step(0, -1); tick();
        drive_step(1, 2);  tick();
        drive_step(0, 1);  tick();
        tick_to(20);
        drain();

        // Random activity on both channels in 16-cycle windows
        win_len = 8'd15;
        do_reset();
        for (int j = 0; j < 240; j++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                case ($urandom_range(0, 5))
                    2, 3:    drive_step(ch, 1);
                    4:       drive_step(ch, -1);
                    5:       drive_step(ch, 2);
                    default: drive_step(ch, 0);
                endcase
            end
            tick();
        end
        tick_to(300);
        drain();

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
